// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op codes, FSM states and small decode helpers for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;
  localparam int B_MDOP = 3;
  localparam logic [B_MDOP-1:0] MD_MULT  = 3'd0;
  localparam logic [B_MDOP-1:0] MD_MULTU = 3'd1;
  localparam logic [B_MDOP-1:0] MD_DIV   = 3'd2;
  localparam logic [B_MDOP-1:0] MD_DIVU  = 3'd3;
  localparam logic [B_MDOP-1:0] MD_MTHI  = 3'd4;
  localparam logic [B_MDOP-1:0] MD_MTLO  = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_e;
  function automatic logic is_arith(input logic [B_MDOP-1:0] op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction
  function automatic logic is_signed_op(input logic [B_MDOP-1:0] op);
    return op == MD_MULT || op == MD_DIV;
  endfunction
  function automatic logic is_div_op(input logic [B_MDOP-1:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/muldiv_unit_step.sv
// muldiv_unit_step: BPC iterations of shift-add multiply or restoring divide on a {high, low} accumulator.
module muldiv_unit_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0] rem, diff, sum;
  always_comb begin
    acc_o = acc_i;
    rem = '0;
    diff = '0;
    sum = '0;
    for (int i = 0; i < BPC; i++) begin
      if (is_div) begin
        // partial remainder with the next dividend bit shifted in; bit WIDTH of diff is the borrow
        rem = acc_o[2*WIDTH-1:WIDTH-1];
        diff = rem - {1'b0, opnd};
        acc_o = diff[WIDTH] ? {acc_o[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc_o[WIDTH-2:0], 1'b1};
      end else begin
        sum = {1'b0, acc_o[2*WIDTH-1:WIDTH]} + (acc_o[0] ? {1'b0, opnd} : '0);
        acc_o = {sum, acc_o[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle mult/div FSM owning HI/LO, with abort and mthi/mtlo writes.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [B_MDOP-1:0] op_code,
  input  logic [WIDTH-1:0]  rs,
  input  logic [WIDTH-1:0]  rt,
  input  logic              abort,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod, res;
  logic [WIDTH-1:0] opnd_q, opnd_d, rs_q, rs_d, rt_q, rt_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] abs_rs, abs_rt, quo, rem;
  logic [B_MDOP-1:0] op_q, op_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d, div_zero_q, div_zero_d;
  logic accept, sgn, div_op;
  muldiv_unit_step #(.WIDTH(WIDTH), .BPC(BITS_PER_CYCLE)) u_step (
    .is_div(div_op),
    .acc_i (acc_q),
    .opnd  (opnd_q),
    .acc_o (step_acc)
  );
  assign op_ready = state_q == S_IDLE && !done_q;
  assign accept   = op_valid && op_ready && !abort;
  assign sgn      = is_signed_op(op_q);
  assign div_op   = is_div_op(op_q);
  assign abs_rs   = sgn && rs_q[WIDTH-1] ? -rs_q : rs_q;
  assign abs_rt   = sgn && rt_q[WIDTH-1] ? -rt_q : rt_q;
  assign prod     = qneg_q ? -acc_q : acc_q;
  assign quo      = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  // divide-by-zero bypasses the sign fix-up: HI gets the raw dividend, LO all ones
  assign res      = !div_op ? prod : ~|rt_q ? {rs_q, {WIDTH{1'b1}}} : {rem, quo};
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = state_q != S_IDLE;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opnd_d = opnd_q;
    op_d = op_q;
    rs_d = rs_q;
    rt_d = rt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    div_zero_d = div_zero_q;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          div_zero_d = 1'b0;
          hi_d = op_code == MD_MTHI ? rs : hi_q;
          lo_d = op_code == MD_MTLO ? rs : lo_q;
          state_d = is_arith(op_code) ? S_PREP : S_IDLE;
          op_d = op_code;
          rs_d = rs;
          rt_d = rt;
        end
        S_PREP: begin
          acc_d = {{WIDTH{1'b0}}, abs_rs};
          opnd_d = abs_rt;
          qneg_d = sgn && (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
          rneg_d = sgn && rs_q[WIDTH-1];
          cnt_d = CW'(N - 1);
          state_d = S_ITER;
        end
        S_ITER: begin
          acc_d = step_acc;
          cnt_d = cnt_q - CW'(1);
          state_d = cnt_q == '0 ? S_FIX : S_ITER;
        end
        default: begin
          state_d = S_IDLE;
          {hi_d, lo_d} = res;
          done_d = 1'b1;
          div_zero_d = div_op && ~|rt_q;
        end
      endcase
    end
  end
  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opnd_q <= '0;
      op_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opnd_q <= opnd_d;
      op_q <= op_d;
      rs_q <= rs_d;
      rt_q <= rt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      div_zero_q <= div_zero_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random ops on BPC=1 and BPC=4 instances, checked against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  logic clk_cpu = 1'b0, reset = 1'b0, op_valid = 1'b0, abort = 1'b0;
  logic [2:0] op_code = 3'd0;
  logic [31:0] rs = '0, rt = '0;
  logic op_ready, busy, done, div_zero, op_ready4, busy4, done4, div_zero4;
  logic [31:0] hi, lo, hi4, lo4;
  int n_err = 0, n_chk = 0;
  always #5 clk_cpu = ~clk_cpu;
  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk_cpu(clk_cpu), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .rs(rs), .rt(rt), .abort(abort), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );
  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk_cpu(clk_cpu), .reset(reset), .op_valid(op_valid), .op_ready(op_ready4), .op_code(op_code),
    .rs(rs), .rt(rt), .abort(abort), .hi(hi4), .lo(lo4), .busy(busy4), .done(done4), .div_zero(div_zero4)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_cpu);
    #1;
  endtask
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    if (op == MD_MULT) return sa * sb;
    if (op == MD_MULTU) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == MD_DIV) return {32'(sa % sb), 32'(sa / sb)};
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp = model(op, a, b);
    logic dz = (op == MD_DIV || op == MD_DIVU) && b == 32'd0;
    int c = 0, c4 = -1;
    op_valid = 1'b1;
    op_code = op;
    rs = a;
    rt = b;
    tick;
    op_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    while (!done && c < 100) begin
      tick;
      c++;
      if (done4 && c4 < 0) c4 = c;
    end
    check("latency_bpc1", 64'(c), 64'd34);
    check("latency_bpc4", 64'(c4), 64'd10);
    check("hilo_bpc1", {hi, lo}, exp);
    check("hilo_bpc4", {hi4, lo4}, exp);
    check("div_zero_bpc1", 64'(div_zero), 64'(dz));
    check("div_zero_bpc4", 64'(div_zero4), 64'(dz));
    check("busy_at_done", 64'(busy), 64'd0);
    check("ready_at_done", 64'(op_ready), 64'd0);
    tick;
    check("ready_after_done", 64'(op_ready), 64'd1);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask
  initial begin
    logic seen;
    tick;
    tick;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_ready", 64'(op_ready), 64'd1);
    reset = 1'b1;
    tick;
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(MD_MULT, -32'sd7, 32'd3);
    check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(MD_DIV, -32'sd7, 32'd2);
    check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MD_DIVU, 32'd100, 32'd0);
    check("divu_zero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    check("divu_zero_flag", 64'(div_zero), 64'd1);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    op_valid = 1'b1;
    op_code = MD_MTHI;
    rs = 32'h1234;
    tick;
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_hi", 64'(hi), 64'h1234);
    op_code = MD_MTLO;
    rs = 32'h5678;
    tick;
    op_valid = 1'b0;
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mt_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    check("mt_done", 64'(done), 64'd0);
    tick;
    check("mt_busy_after", 64'(busy), 64'd0);
    op_valid = 1'b1;
    op_code = MD_DIVU;
    rs = 32'd1000;
    rt = 32'd7;
    tick;
    op_valid = 1'b0;
    repeat (11) tick;
    check("abort_busy_before", 64'(busy), 64'd1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_ready", 64'(op_ready), 64'd1);
    check("abort_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    seen = 1'b0;
    repeat (40) begin
      tick;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    op_valid = 1'b1;
    abort = 1'b1;
    op_code = MD_MTHI;
    rs = 32'hDEAD;
    tick;
    op_valid = 1'b0;
    abort = 1'b0;
    check("abort_mthi", 64'(hi), 64'h1234);
    op_valid = 1'b1;
    op_code = MD_MULT;
    rs = 32'd3;
    rt = 32'd5;
    tick;
    op_valid = 1'b0;
    repeat (33) tick;
    check("fix_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("fix_abort_done", 64'(done), 64'd0);
    check("fix_abort_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    op_valid = 1'b1;
    op_code = MD_MULTU;
    rs = 32'hFF;
    rt = 32'hFF;
    tick;
    op_valid = 1'b0;
    repeat (5) tick;
    #2 reset = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    check("async_rst_busy4", 64'(busy4), 64'd0);
    tick;
    reset = 1'b1;
    tick;
    repeat (40) begin
      logic [2:0] op = 3'($urandom_range(0, 3));
      logic [31:0] a = $urandom_range(0, 7) == 0 ? 32'h8000_0000 : $urandom;
      int r = $urandom_range(0, 9);
      logic [31:0] b = r == 0 ? 32'd0 : r < 3 ? 32'($urandom_range(1, 15)) : r == 3 ? 32'hFFFF_FFFF : $urandom;
      run_op(op, a, b);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
